hazard_scoreboard: RTL and testbench

- Pipeline hazard controller for the 5-stage core, sitting between ID and EX control.
- Detects load-use RAW hazards with a configurable stall depth, RAW/WAW hazards and structural hazards against one multi-cycle (mul/div) unit, and branch flushes.
- Drives PC/IF-ID write enables, ID-EX bubble insertion and IF-ID flush, and reports stall cause plus a stall-cycle performance counter.

---
 rtl/hazard_pkg.sv | 22 ++
 rtl/hazard_scoreboard_if.sv | 44 ++++
 rtl/long_op_tracker.sv | 55 +++++
 rtl/hazard_scoreboard.sv | 102 ++++++++++
 tb/tb_hazard_scoreboard.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/hazard_pkg.sv
// Shared types for the ID/EX hazard scoreboard: register index type,
// stall cause encoding and the register-match rule used by all hazard checks.
package hazard_pkg;

    localparam int REG_IDX_W = 5;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;

    typedef enum logic [2:0] {
        NONE     = 3'd0,
        LOAD_USE = 3'd1,
        LONG_RAW = 3'd2,
        LONG_WAW = 3'd3,
        STRUCT   = 3'd4
    } stall_cause_e;

    // Two indices collide unless they are the hardwired-zero register.
    function automatic logic reg_match(input reg_idx_t a, input reg_idx_t b, input logic x0_hw);
        return (a == b) && !(x0_hw && (a == '0));
    endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// ID/EX-side signals seen by the hazard scoreboard. The pipeline drives the
// master side; the scoreboard sits on the slave side.
interface hazard_scoreboard_if #(
    parameter int CNT_W = 32
);
    import hazard_pkg::*;

    logic             id_valid;
    reg_idx_t         id_rs1;
    reg_idx_t         id_rs2;
    logic             id_rs1_used;
    logic             id_rs2_used;
    reg_idx_t         id_rd;
    logic             id_reg_write;
    logic             id_is_long;
    logic             ex_valid;
    logic             ex_mem_read;
    reg_idx_t         ex_rd;
    logic             branch_flush;

    logic             stall;
    logic             pc_write;
    logic             if_id_write;
    logic             id_ex_bubble;
    logic             if_id_flush;
    logic             long_busy;
    stall_cause_e     stall_cause;
    logic [CNT_W-1:0] stall_count;

    modport master (
        output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd,
               id_reg_write, id_is_long, ex_valid, ex_mem_read, ex_rd, branch_flush,
        input  stall, pc_write, if_id_write, id_ex_bubble, if_id_flush,
               long_busy, stall_cause, stall_count
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd,
               id_reg_write, id_is_long, ex_valid, ex_mem_read, ex_rd, branch_flush,
        output stall, pc_write, if_id_write, id_ex_bubble, if_id_flush,
               long_busy, stall_cause, stall_count
    );

endinterface

// File: rtl/long_op_tracker.sv
// Tracks the single in-flight multi-cycle (mul/div) op: remaining latency,
// destination and whether it writes, and flags RAW/WAW collisions with ID.
module long_op_tracker
    import hazard_pkg::*;
#(
    parameter int LONG_LAT     = 4,
    parameter int X0_HARDWIRED = 1
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     issue,
    input  logic     id_valid,
    input  reg_idx_t id_rs1,
    input  logic     id_rs1_used,
    input  reg_idx_t id_rs2,
    input  logic     id_rs2_used,
    input  reg_idx_t id_rd,
    input  logic     id_reg_write,
    output logic     busy,
    output logic     raw_hit,
    output logic     waw_hit
);

    localparam logic [3:0] LAT   = 4'(LONG_LAT);
    localparam logic       X0_HW = (X0_HARDWIRED != 0);

    logic [3:0] long_cnt;
    reg_idx_t   long_rd;
    logic       long_wr;
    logic       pending;

    // Load latency on issue, otherwise count down to idle; rd/wr persist.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            long_cnt <= '0;
            long_rd  <= '0;
            long_wr  <= 1'b0;
        end else if (issue) begin
            long_cnt <= LAT;
            long_rd  <= id_rd;
            long_wr  <= id_reg_write && ((id_rd != '0) || !X0_HW);
        end else if (long_cnt != 4'd0) begin
            long_cnt <= long_cnt - 4'd1;
        end
    end

    // At long_cnt==1 the result is on the forwarding path, so only >1 blocks.
    assign pending = (long_cnt > 4'd1) && long_wr && id_valid;
    assign busy    = (long_cnt != 4'd0);
    assign raw_hit = pending &&
                     ((id_rs1_used && reg_match(long_rd, id_rs1, X0_HW)) ||
                      (id_rs2_used && reg_match(long_rd, id_rs2, X0_HW)));
    assign waw_hit = pending && id_reg_write && reg_match(long_rd, id_rd, X0_HW);

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard controller between ID and EX: load-use, long-op RAW/WAW and
// structural stalls, branch flush, stall cause and saturating stall counter.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int LOAD_USE_STALL = 1,
    parameter int LONG_LAT       = 4,
    parameter int CNT_W          = 32,
    parameter int X0_HARDWIRED   = 1
) (
    input  logic                clk,
    input  logic                rst,
    hazard_scoreboard_if.slave  bus
);

    localparam logic [1:0] LU_INIT = 2'(LOAD_USE_STALL - 1);
    localparam logic       X0_HW   = (X0_HARDWIRED != 0);

    logic         [1:0] lu_cnt;
    logic               lu_cond;
    logic               lu_hit;
    logic               long_busy;
    logic               raw_hit;
    logic               waw_hit;
    logic               struct_hit;
    logic               stall_int;
    logic               issue;
    stall_cause_e       cause;
    logic   [CNT_W-1:0] stall_count;

    assign lu_cond = bus.id_valid && bus.ex_valid && bus.ex_mem_read &&
                     ((bus.id_rs1_used && reg_match(bus.ex_rd, bus.id_rs1, X0_HW)) ||
                      (bus.id_rs2_used && reg_match(bus.ex_rd, bus.id_rs2, X0_HW)));
    assign lu_hit     = lu_cond || (lu_cnt != 2'd0);
    assign struct_hit = long_busy && bus.id_is_long && bus.id_valid;
    // rst gating keeps the outputs at their idle values while reset is held.
    assign stall_int  = (lu_hit || raw_hit || waw_hit || struct_hit) &&
                        !bus.branch_flush && !rst;
    assign issue      = bus.id_valid && bus.id_is_long && !stall_int && !bus.branch_flush;

    long_op_tracker #(
        .LONG_LAT     (LONG_LAT),
        .X0_HARDWIRED (X0_HARDWIRED)
    ) u_long (
        .clk          (clk),
        .rst          (rst),
        .issue        (issue),
        .id_valid     (bus.id_valid),
        .id_rs1       (bus.id_rs1),
        .id_rs1_used  (bus.id_rs1_used),
        .id_rs2       (bus.id_rs2),
        .id_rs2_used  (bus.id_rs2_used),
        .id_rd        (bus.id_rd),
        .id_reg_write (bus.id_reg_write),
        .busy         (long_busy),
        .raw_hit      (raw_hit),
        .waw_hit      (waw_hit)
    );

    // Load-use extension counter; a flush abandons any remaining stall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lu_cnt <= 2'd0;
        end else if (bus.branch_flush) begin
            lu_cnt <= 2'd0;
        end else if (lu_cond && (lu_cnt == 2'd0)) begin
            lu_cnt <= LU_INIT;
        end else if (lu_cnt != 2'd0) begin
            lu_cnt <= lu_cnt - 2'd1;
        end
    end

    // Saturating count of cycles the front end was held.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_count <= '0;
        end else if (stall_int && (stall_count != '1)) begin
            stall_count <= stall_count + CNT_W'(1);
        end
    end

    // Highest-priority active hazard names the stall.
    always_comb begin
        cause = NONE;
        if (stall_int) begin
            if (lu_hit)       cause = LOAD_USE;
            else if (raw_hit) cause = LONG_RAW;
            else if (waw_hit) cause = LONG_WAW;
            else              cause = STRUCT;
        end
    end

    assign bus.stall        = stall_int;
    assign bus.pc_write     = !stall_int;
    assign bus.if_id_write  = !stall_int;
    assign bus.id_ex_bubble = !rst && (stall_int || bus.branch_flush);
    assign bus.if_id_flush  = !rst && bus.branch_flush;
    assign bus.long_busy    = long_busy;
    assign bus.stall_cause  = cause;
    assign bus.stall_count  = stall_count;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scoreboard bench: each cycle the driver computes the expected outputs from
// a behavioural model and queues them; the monitor compares DUT outputs.
module tb_hazard_scoreboard;
    import hazard_pkg::*;

    localparam int LUS = 2;
    localparam int LAT = 4;
    localparam int CW  = 6;
    localparam int SAT = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    hazard_scoreboard_if #(.CNT_W(CW)) bus ();

    hazard_scoreboard #(
        .LOAD_USE_STALL (LUS),
        .LONG_LAT       (LAT),
        .CNT_W          (CW),
        .X0_HARDWIRED   (1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        bit stall;
        bit pc_write;
        bit if_id_write;
        bit bubble;
        bit flush;
        bit busy;
        int cause;
        int count;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;

    // Behavioural state: remaining stall/latency cycles and stall total.
    int lu_left, long_left, long_dest, nstalls;
    bit long_writes;

    function automatic bit m(int a, int b);
        return (a == b) && (a != 0);
    endfunction

    function automatic bit reads(int r);
        return (bus.id_rs1_used && m(r, int'(bus.id_rs1))) ||
               (bus.id_rs2_used && m(r, int'(bus.id_rs2)));
    endfunction

    task automatic eval_push();
        exp_t e;
        bit lu_now, lu, pend, raw, waw, st, stl;
        if (rst) begin
            lu_left = 0; long_left = 0; long_dest = 0; long_writes = 0; nstalls = 0;
        end
        lu_now = !rst && bus.id_valid && bus.ex_valid && bus.ex_mem_read && reads(int'(bus.ex_rd));
        lu     = lu_now || (lu_left > 0);
        pend   = (long_left > 1) && long_writes && bus.id_valid;
        raw    = pend && reads(long_dest);
        waw    = pend && bus.id_reg_write && m(long_dest, int'(bus.id_rd));
        st     = (long_left > 0) && bus.id_valid && bus.id_is_long;
        stl    = !rst && !bus.branch_flush && (lu || raw || waw || st);
        e.stall       = stl;
        e.pc_write    = !stl;
        e.if_id_write = !stl;
        e.bubble      = !rst && (stl || bus.branch_flush);
        e.flush       = !rst && bus.branch_flush;
        e.busy        = long_left > 0;
        e.count       = nstalls;
        e.cause       = !stl ? 0 : lu ? 1 : raw ? 2 : waw ? 3 : 4;
        q.push_back(e);
        if (rst) return;
        if (bus.branch_flush)            lu_left = 0;
        else if (lu_now && lu_left == 0) lu_left = LUS - 1;
        else if (lu_left > 0)            lu_left--;
        if (bus.id_valid && bus.id_is_long && !stl && !bus.branch_flush) begin
            long_left   = LAT;
            long_dest   = int'(bus.id_rd);
            long_writes = bus.id_reg_write && (bus.id_rd != 0);
        end else if (long_left > 0) begin
            long_left--;
        end
        if (stl && nstalls < SAT) nstalls++;
    endtask

    task automatic clear_in();
        bus.id_valid = 0; bus.id_rs1 = 0; bus.id_rs2 = 0; bus.id_rs1_used = 0;
        bus.id_rs2_used = 0; bus.id_rd = 0; bus.id_reg_write = 0; bus.id_is_long = 0;
        bus.ex_valid = 0; bus.ex_mem_read = 0; bus.ex_rd = 0; bus.branch_flush = 0;
    endtask

    task automatic cyc();
        eval_push();
        @(negedge clk);
    endtask

    task automatic rand_in();
        bus.id_valid     = ($urandom_range(0, 99) < 85);
        bus.id_rs1       = reg_idx_t'($urandom_range(0, 3));
        bus.id_rs2       = reg_idx_t'($urandom_range(0, 3));
        bus.id_rs1_used  = 1'($urandom_range(0, 1));
        bus.id_rs2_used  = 1'($urandom_range(0, 1));
        bus.id_rd        = reg_idx_t'($urandom_range(0, 3));
        bus.id_reg_write = ($urandom_range(0, 99) < 70);
        bus.id_is_long   = ($urandom_range(0, 99) < 20);
        bus.ex_valid     = 1'($urandom_range(0, 1));
        bus.ex_mem_read  = 1'($urandom_range(0, 1));
        bus.ex_rd        = reg_idx_t'($urandom_range(0, 3));
        bus.branch_flush = ($urandom_range(0, 99) < 8);
    endtask

    // Monitor: outputs are combinational on this cycle's inputs, sampled mid-phase.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (q.size() != 0) begin
                e = q.pop_front();
                checks++;
                if (bus.stall !== e.stall || bus.pc_write !== e.pc_write ||
                    bus.if_id_write !== e.if_id_write || bus.id_ex_bubble !== e.bubble ||
                    bus.if_id_flush !== e.flush || bus.long_busy !== e.busy ||
                    int'(bus.stall_cause) != e.cause || int'(bus.stall_count) != e.count) begin
                    failures++;
                    $display("FAIL outputs t=%0t got stall=%b pc=%b ifid=%b bub=%b fl=%b busy=%b cause=%0d cnt=%0d exp stall=%b pc=%b ifid=%b bub=%b fl=%b busy=%b cause=%0d cnt=%0d",
                             $time, bus.stall, bus.pc_write, bus.if_id_write, bus.id_ex_bubble,
                             bus.if_id_flush, bus.long_busy, bus.stall_cause, bus.stall_count,
                             e.stall, e.pc_write, e.if_id_write, e.bubble, e.flush, e.busy,
                             e.cause, e.count);
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        clear_in();
        @(negedge clk);
        cyc(); cyc();
        rst = 1'b0;
        cyc();

        // Load-use on rs2, then the bubble reaches EX and the counter holds the stall.
        bus.id_valid = 1; bus.id_rs2 = 5; bus.id_rs2_used = 1;
        bus.ex_valid = 1; bus.ex_mem_read = 1; bus.ex_rd = 5;
        cyc();
        bus.ex_valid = 0;
        cyc(); cyc();
        // Same pattern against x0, then an unused rs1 match.
        bus.id_rs2 = 0; bus.ex_rd = 0; bus.ex_valid = 1;
        cyc();
        clear_in();
        bus.id_valid = 1; bus.id_rs1 = 5; bus.ex_valid = 1; bus.ex_mem_read = 1; bus.ex_rd = 5;
        cyc();

        // Long op to x7 then a consumer of x7.
        clear_in();
        bus.id_valid = 1; bus.id_is_long = 1; bus.id_rd = 7; bus.id_reg_write = 1;
        cyc();
        clear_in();
        bus.id_valid = 1; bus.id_rs1 = 7; bus.id_rs1_used = 1;
        repeat (5) cyc();

        // Back-to-back long ops (structural), then WAW on x7.
        clear_in();
        bus.id_valid = 1; bus.id_is_long = 1; bus.id_rd = 7; bus.id_reg_write = 1;
        repeat (7) cyc();
        bus.id_is_long = 0;
        repeat (2) cyc();
        bus.id_is_long = 1;
        cyc();
        bus.id_is_long = 0;
        repeat (4) cyc();

        // Flush arriving during a load-use stall.
        clear_in();
        bus.id_valid = 1; bus.id_rs1 = 3; bus.id_rs1_used = 1;
        bus.ex_valid = 1; bus.ex_mem_read = 1; bus.ex_rd = 3;
        cyc();
        bus.ex_valid = 0; bus.branch_flush = 1;
        cyc();
        bus.branch_flush = 0;
        cyc();

        // Async reset while the long op sits at long_cnt=3 with a hazard present.
        clear_in();
        bus.id_valid = 1; bus.id_is_long = 1; bus.id_rd = 9; bus.id_reg_write = 1;
        cyc();
        clear_in();
        cyc();
        bus.id_valid = 1; bus.id_rs1 = 9; bus.id_rs1_used = 1;
        bus.ex_valid = 1; bus.ex_mem_read = 1; bus.ex_rd = 9;
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        cyc();

        // Random traffic; enough stalls to drive the 6-bit counter into saturation.
        repeat (600) begin
            rand_in();
            cyc();
        end
        clear_in();
        cyc();

        #5;
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d required=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
